pixel_stream_arbiter: RTL

Merges the flushed pixel streams of NUM_LANES parallel tile pixel processors onto a single framebuffer-write channel. It uses round-robin arbitration with a per-tile burst lock: once a lane is granted, it owns the channel until it has transferred one full tile (BURST_LEN pixels), so tile flushes are never interleaved. An idle timeout releases a lane that stalls mid-burst. The block sits between the pixel processor array and the framebuffer writer.

---
 rtl/pixel_stream_arbiter.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/pixel_stream_arbiter.sv
// pixel_stream_arbiter
//   Merges the flushed pixel streams of NUM_LANES tile pixel processors onto
//   one framebuffer-write channel. Round-robin grant with a per-tile burst
//   lock: a granted lane keeps the channel for BURST_LEN pixels so tile
//   flushes never interleave. A lane that goes idle mid-burst for TIMEOUT
//   cycles is released.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   lane_vld        per-lane pixel valid
//   lane_color      per-lane colour, lane i at [i*COLOR_BITS +: COLOR_BITS]
//   lane_pixel      per-lane {y,x} coordinate, lane i at [i*COORD_BITS +: COORD_BITS]
//   lane_rdy        per-lane ready, one-hot or zero
//   vld_out/rdy_in  output handshake
//   color_out       output colour
//   pixel_out       output coordinate
//   lane_out        source lane of the output pixel
//   burst_done      one-cycle pulse, burst completed normally
//   burst_abort     one-cycle pulse, burst released by idle timeout
//
// state | meaning
// IDLE  | no owner; pick next requester from rr_ptr upward (costs one cycle)
// BURST | grant owns the channel until BURST_LEN transfers or idle timeout

module pixel_stream_arbiter #(
    parameter int NUM_LANES  = 4,
    parameter int COLOR_BITS = 8,
    parameter int COORD_BITS = 32,
    parameter int BURST_LEN  = 64,
    parameter int TIMEOUT    = 255
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_LANES-1:0]               lane_vld,
    input  logic [NUM_LANES*COLOR_BITS-1:0]    lane_color,
    input  logic [NUM_LANES*COORD_BITS-1:0]    lane_pixel,
    output logic [NUM_LANES-1:0]               lane_rdy,
    output logic                               vld_out,
    input  logic                               rdy_in,
    output logic [COLOR_BITS-1:0]              color_out,
    output logic [COORD_BITS-1:0]              pixel_out,
    output logic [$clog2(NUM_LANES)-1:0]       lane_out,
    output logic                               burst_done,
    output logic                               burst_abort
);

    localparam int LANE_W = $clog2(NUM_LANES);
    localparam int CNT_W  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [LANE_W-1:0]   grant_q, grant_d;
    logic [LANE_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [7:0]          idle_q, idle_d;
    logic                done_d, abort_d;

    logic                sel_vld;
    logic [COLOR_BITS-1:0] sel_color;
    logic [COORD_BITS-1:0] sel_pixel;
    logic                take;
    logic                xfer;
    logic                pick_found;
    logic [LANE_W-1:0]   pick_idx;
    logic [LANE_W-1:0]   grant_next;

    // The output register can accept a pixel when empty or draining this cycle.
    assign take = (state_q == BURST) && (!vld_out || rdy_in);
    assign xfer = take && sel_vld;

    assign grant_next = (grant_q == LANE_W'(NUM_LANES - 1)) ? '0 : grant_q + LANE_W'(1);

    always_comb begin
        sel_vld   = 1'b0;
        sel_color = '0;
        sel_pixel = '0;
        lane_rdy  = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (grant_q == LANE_W'(i)) begin
                sel_vld     = lane_vld[i];
                sel_color   = lane_color[i*COLOR_BITS +: COLOR_BITS];
                sel_pixel   = lane_pixel[i*COORD_BITS +: COORD_BITS];
                lane_rdy[i] = take;
            end
        end
    end

    // Round-robin search: first requester at or above rr_ptr, then wrap to 0.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int j = 0; j < NUM_LANES; j++) begin
            if (!pick_found && lane_vld[j] && (LANE_W'(j) >= rr_ptr_q)) begin
                pick_found = 1'b1;
                pick_idx   = LANE_W'(j);
            end
        end
        for (int j = 0; j < NUM_LANES; j++) begin
            if (!pick_found && lane_vld[j]) begin
                pick_found = 1'b1;
                pick_idx   = LANE_W'(j);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        count_d  = count_q;
        idle_d   = idle_q;
        done_d   = 1'b0;
        abort_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_d = pick_idx;
                    count_d = '0;
                    idle_d  = '0;
                    state_d = BURST;
                end
            end
            BURST: begin
                if (xfer) begin
                    idle_d = '0;
                    if (count_q == CNT_W'(BURST_LEN - 1)) begin
                        done_d   = 1'b1;
                        rr_ptr_d = grant_next;
                        count_d  = '0;
                        state_d  = IDLE;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end else if (!sel_vld) begin
                    // Only a silent lane ages; downstream stalls never time out.
                    if (idle_q == 8'(TIMEOUT - 1)) begin
                        abort_d  = 1'b1;
                        rr_ptr_d = grant_next;
                        count_d  = '0;
                        idle_d   = '0;
                        state_d  = IDLE;
                    end else begin
                        idle_d = idle_q + 8'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            count_q     <= '0;
            idle_q      <= '0;
            burst_done  <= 1'b0;
            burst_abort <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            count_q     <= count_d;
            idle_q      <= idle_d;
            burst_done  <= done_d;
            burst_abort <= abort_d;
        end
    end

    // Single-entry output stage; drains independently of the arbiter state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_out   <= 1'b0;
            color_out <= '0;
            pixel_out <= '0;
            lane_out  <= '0;
        end else if (xfer) begin
            vld_out   <= 1'b1;
            color_out <= sel_color;
            pixel_out <= sel_pixel;
            lane_out  <= grant_q;
        end else if (rdy_in) begin
            vld_out   <= 1'b0;
        end
    end

endmodule
